// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the reorder buffer.
// Entry i is tagged i+1 so that tag 0 can mean "operand already in the register file".
package reorder_buffer_pkg;

    localparam int ROB_LEN  = 4;
    localparam int ROB_SIZE = 1 << ROB_LEN;
    localparam int TAG_LEN  = ROB_LEN + 1;
    localparam int DATA_LEN = 32;
    localparam int ADDR_LEN = 32;
    localparam int REG_LEN  = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;

    // Occupancy thresholds in the counter's own width.
    localparam logic [TAG_LEN-1:0] ROB_CAP       = TAG_LEN'(ROB_SIZE);
    localparam logic [TAG_LEN-1:0] ROB_FULL_MARK = TAG_LEN'(ROB_SIZE - 1);

    typedef logic [TAG_LEN-1:0] rob_tag_t;
    typedef logic [ROB_LEN-1:0] rob_idx_t;

    // Tag ROB_SIZE has all low bits zero, so the wrap of the subtraction maps it
    // onto the last entry.
    function automatic rob_idx_t tag_to_idx(input rob_tag_t tag);
        return tag[ROB_LEN-1:0] - rob_idx_t'(1);
    endfunction

    function automatic rob_tag_t idx_to_tag(input rob_idx_t idx);
        return {1'b0, idx} + rob_tag_t'(1);
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// Combinational operand lookup for the dispatcher.
// Ports:
//   q                      tag being queried (0 = no dependency)
//   entry_ready/entry_data per-entry ready flags and captured values
//   alu_*/lsb_*            result broadcasts of this cycle (bypassed)
//   ready/value            operand available and its value
module rob_query_port
    import reorder_buffer_pkg::*;
(
    input  rob_tag_t                          q,
    input  logic [ROB_SIZE-1:0]               entry_ready,
    input  logic [ROB_SIZE-1:0][DATA_LEN-1:0] entry_data,
    input  logic                              alu_valid,
    input  rob_tag_t                          alu_rob_id,
    input  logic [DATA_LEN-1:0]               alu_data,
    input  logic                              lsb_valid,
    input  rob_tag_t                          lsb_rob_id,
    input  logic [DATA_LEN-1:0]               lsb_data,
    output logic                              ready,
    output logic [DATA_LEN-1:0]               value
);

    rob_idx_t idx;
    logic     alu_hit;
    logic     lsb_hit;

    always_comb begin
        idx     = tag_to_idx(q);
        alu_hit = alu_valid && (alu_rob_id == q);
        lsb_hit = lsb_valid && (lsb_rob_id == q);
        ready   = FALSE;
        value   = ZERO_WORD;
        if (q == '0) begin
            ready = TRUE;
        end else begin
            ready = entry_ready[idx] || alu_hit || lsb_hit;
            // A result on a bus this cycle is newer than anything stored.
            if (alu_hit)
                value = alu_data;
            else if (lsb_hit)
                value = lsb_data;
            else
                value = entry_data[idx];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries for the dispatcher, answers operand
// queries with bus bypass, captures ALU/LSB results, retires in order to the
// register file or LSB, and flushes on a mispredicted jump.
// Ports:
//   clk, rst (async, active-high), rdy (global enable)
//   *_from_dsp / rob_id_to_dsp / full_to_if   allocation interface
//   Q*_from_dsp / Q*_ready_to_dsp / V*_to_dsp operand queries
//   alu_* / lsb_*                             result broadcast buses
//   *_to_reg, commit_*_to_lsb                 commit outputs (registered pulses)
//   rollback_flag / target_pc_to_if           flush and redirect
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                ena_from_dsp,
    input  logic [REG_LEN-1:0]  rd_from_dsp,
    input  logic [ADDR_LEN-1:0] pc_from_dsp,
    input  logic                is_store_from_dsp,
    output logic [ROB_LEN:0]    rob_id_to_dsp,
    output logic                full_to_if,
    input  logic [ROB_LEN:0]    Q1_from_dsp,
    input  logic [ROB_LEN:0]    Q2_from_dsp,
    output logic                Q1_ready_to_dsp,
    output logic                Q2_ready_to_dsp,
    output logic [DATA_LEN-1:0] V1_to_dsp,
    output logic [DATA_LEN-1:0] V2_to_dsp,
    input  logic                alu_valid,
    input  logic [ROB_LEN:0]    alu_rob_id,
    input  logic [DATA_LEN-1:0] alu_data,
    input  logic                alu_jump,
    input  logic [ADDR_LEN-1:0] alu_target,
    input  logic                lsb_valid,
    input  logic [ROB_LEN:0]    lsb_rob_id,
    input  logic [DATA_LEN-1:0] lsb_data,
    output logic                ena_to_reg,
    output logic [REG_LEN-1:0]  rd_to_reg,
    output logic [ROB_LEN:0]    Q_to_reg,
    output logic [DATA_LEN-1:0] data_to_reg,
    output logic                commit_store_to_lsb,
    output logic [ROB_LEN:0]    commit_rob_id_to_lsb,
    output logic                rollback_flag,
    output logic [ADDR_LEN-1:0] target_pc_to_if
);

    logic [ROB_SIZE-1:0]               busy_reg, busy_next;
    logic [ROB_SIZE-1:0]               ready_reg, ready_next;
    logic [ROB_SIZE-1:0]               jump_reg, jump_next;
    logic [ROB_SIZE-1:0]               store_reg, store_next;
    logic [ROB_SIZE-1:0][DATA_LEN-1:0] data_reg, data_next;
    logic [ROB_SIZE-1:0][ADDR_LEN-1:0] target_reg, target_next;
    logic [ROB_SIZE-1:0][REG_LEN-1:0]  rd_reg, rd_next;
    rob_idx_t                          head_reg, head_next;
    rob_idx_t                          tail_reg, tail_next;
    logic [ROB_LEN:0]                  count_reg, count_next;

    logic                commit_ena_reg, commit_ena_next;
    logic [REG_LEN-1:0]  commit_rd_reg, commit_rd_next;
    rob_tag_t            commit_tag_reg, commit_tag_next;
    logic [DATA_LEN-1:0] commit_data_reg, commit_data_next;
    logic                commit_store_reg, commit_store_next;
    rob_tag_t            store_tag_reg, store_tag_next;
    logic                rollback_reg, rollback_next;
    logic [ADDR_LEN-1:0] redirect_pc_reg, redirect_pc_next;

    logic                do_alloc;
    logic                do_commit;
    logic                do_rollback;
    logic [ROB_SIZE-1:0] alu_hit;
    logic [ROB_SIZE-1:0] lsb_hit;

    // The pc travels with the instruction for debug only; nothing here consumes it.
    logic unused_pc;
    assign unused_pc = ^pc_from_dsp;

    // Broadcasts land only on live entries; stale tags after a flush fall through.
    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry_hit
            assign alu_hit[gi] = alu_valid && busy_reg[gi]
                                 && (alu_rob_id == idx_to_tag(rob_idx_t'(gi)));
            assign lsb_hit[gi] = lsb_valid && busy_reg[gi]
                                 && (lsb_rob_id == idx_to_tag(rob_idx_t'(gi)));
        end
    endgenerate

    always_comb begin
        do_commit   = (count_reg != '0) && ready_reg[head_reg];
        do_rollback = do_commit && jump_reg[head_reg];
        do_alloc    = ena_from_dsp && (count_reg < ROB_CAP) && !do_rollback;

        busy_next   = busy_reg;
        ready_next  = ready_reg;
        jump_next   = jump_reg;
        store_next  = store_reg;
        data_next   = data_reg;
        target_next = target_reg;
        rd_next     = rd_reg;
        head_next   = head_reg;
        tail_next   = tail_reg;
        count_next  = count_reg;

        for (int i = 0; i < ROB_SIZE; i++) begin
            if (alu_hit[i]) begin
                ready_next[i]  = TRUE;
                data_next[i]   = alu_data;
                jump_next[i]   = alu_jump;
                target_next[i] = alu_target;
            end else if (lsb_hit[i]) begin
                ready_next[i] = TRUE;
                data_next[i]  = lsb_data;
            end
        end

        if (do_commit) begin
            busy_next[head_reg]  = FALSE;
            ready_next[head_reg] = FALSE;
            head_next            = head_reg + rob_idx_t'(1);
        end

        if (do_alloc) begin
            busy_next[tail_reg]  = TRUE;
            ready_next[tail_reg] = FALSE;
            jump_next[tail_reg]  = FALSE;
            rd_next[tail_reg]    = rd_from_dsp;
            store_next[tail_reg] = is_store_from_dsp;
            tail_next            = tail_reg + rob_idx_t'(1);
        end

        case ({do_alloc, do_commit})
            2'b10:   count_next = count_reg + rob_tag_t'(1);
            2'b01:   count_next = count_reg - rob_tag_t'(1);
            default: count_next = count_reg;
        endcase

        // Everything younger than the mispredicted jump is wrong-path work.
        if (do_rollback) begin
            busy_next  = '0;
            ready_next = '0;
            jump_next  = '0;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end

        // Payload registers hold their last committed values between pulses.
        commit_ena_next   = do_commit && !store_reg[head_reg];
        commit_store_next = do_commit && store_reg[head_reg];
        rollback_next     = do_rollback;
        commit_rd_next    = commit_rd_reg;
        commit_tag_next   = commit_tag_reg;
        commit_data_next  = commit_data_reg;
        store_tag_next    = store_tag_reg;
        redirect_pc_next  = redirect_pc_reg;
        if (commit_ena_next) begin
            commit_rd_next   = rd_reg[head_reg];
            commit_tag_next  = idx_to_tag(head_reg);
            commit_data_next = data_reg[head_reg];
        end
        if (commit_store_next)
            store_tag_next = idx_to_tag(head_reg);
        if (do_rollback)
            redirect_pc_next = target_reg[head_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg         <= '0;
            ready_reg        <= '0;
            jump_reg         <= '0;
            store_reg        <= '0;
            data_reg         <= '0;
            target_reg       <= '0;
            rd_reg           <= '0;
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            commit_ena_reg   <= FALSE;
            commit_rd_reg    <= '0;
            commit_tag_reg   <= '0;
            commit_data_reg  <= '0;
            commit_store_reg <= FALSE;
            store_tag_reg    <= '0;
            rollback_reg     <= FALSE;
            redirect_pc_reg  <= '0;
        end else if (rdy) begin
            busy_reg         <= busy_next;
            ready_reg        <= ready_next;
            jump_reg         <= jump_next;
            store_reg        <= store_next;
            data_reg         <= data_next;
            target_reg       <= target_next;
            rd_reg           <= rd_next;
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            count_reg        <= count_next;
            commit_ena_reg   <= commit_ena_next;
            commit_rd_reg    <= commit_rd_next;
            commit_tag_reg   <= commit_tag_next;
            commit_data_reg  <= commit_data_next;
            commit_store_reg <= commit_store_next;
            store_tag_reg    <= store_tag_next;
            rollback_reg     <= rollback_next;
            redirect_pc_reg  <= redirect_pc_next;
        end
    end

    rob_query_port u_query_q1 (
        .q           (Q1_from_dsp),
        .entry_ready (ready_reg),
        .entry_data  (data_reg),
        .alu_valid   (alu_valid),
        .alu_rob_id  (alu_rob_id),
        .alu_data    (alu_data),
        .lsb_valid   (lsb_valid),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_data    (lsb_data),
        .ready       (Q1_ready_to_dsp),
        .value       (V1_to_dsp)
    );

    rob_query_port u_query_q2 (
        .q           (Q2_from_dsp),
        .entry_ready (ready_reg),
        .entry_data  (data_reg),
        .alu_valid   (alu_valid),
        .alu_rob_id  (alu_rob_id),
        .alu_data    (alu_data),
        .lsb_valid   (lsb_valid),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_data    (lsb_data),
        .ready       (Q2_ready_to_dsp),
        .value       (V2_to_dsp)
    );

    assign rob_id_to_dsp = idx_to_tag(tail_reg);
    // One slot of margin: the dispatcher sees full one cycle late.
    assign full_to_if    = (count_reg >= ROB_FULL_MARK);

    // While frozen the pulses are masked; they appear once rdy returns.
    assign ena_to_reg           = commit_ena_reg && rdy;
    assign rd_to_reg            = commit_rd_reg;
    assign Q_to_reg             = commit_tag_reg;
    assign data_to_reg          = commit_data_reg;
    assign commit_store_to_lsb  = commit_store_reg && rdy;
    assign commit_rob_id_to_lsb = store_tag_reg;
    assign rollback_flag        = rollback_reg && rdy;
    assign target_pc_to_if      = redirect_pc_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based model of the in-flight instructions.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        ena_from_dsp = 1'b0;
    logic [4:0]  rd_from_dsp = '0;
    logic [31:0] pc_from_dsp = '0;
    logic        is_store_from_dsp = 1'b0;
    logic [4:0]  rob_id_to_dsp;
    logic        full_to_if;
    logic [4:0]  Q1_from_dsp = '0;
    logic [4:0]  Q2_from_dsp = '0;
    logic        Q1_ready_to_dsp, Q2_ready_to_dsp;
    logic [31:0] V1_to_dsp, V2_to_dsp;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rob_id = '0;
    logic [31:0] alu_data = '0;
    logic        alu_jump = 1'b0;
    logic [31:0] alu_target = '0;
    logic        lsb_valid = 1'b0;
    logic [4:0]  lsb_rob_id = '0;
    logic [31:0] lsb_data = '0;
    logic        ena_to_reg;
    logic [4:0]  rd_to_reg;
    logic [4:0]  Q_to_reg;
    logic [31:0] data_to_reg;
    logic        commit_store_to_lsb;
    logic [4:0]  commit_rob_id_to_lsb;
    logic        rollback_flag;
    logic [31:0] target_pc_to_if;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
        .pc_from_dsp(pc_from_dsp), .is_store_from_dsp(is_store_from_dsp),
        .rob_id_to_dsp(rob_id_to_dsp), .full_to_if(full_to_if),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
        .Q1_ready_to_dsp(Q1_ready_to_dsp), .Q2_ready_to_dsp(Q2_ready_to_dsp),
        .V1_to_dsp(V1_to_dsp), .V2_to_dsp(V2_to_dsp),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
        .alu_jump(alu_jump), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data),
        .ena_to_reg(ena_to_reg), .rd_to_reg(rd_to_reg), .Q_to_reg(Q_to_reg),
        .data_to_reg(data_to_reg), .commit_store_to_lsb(commit_store_to_lsb),
        .commit_rob_id_to_lsb(commit_rob_id_to_lsb),
        .rollback_flag(rollback_flag), .target_pc_to_if(target_pc_to_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: oldest instruction at the front of the queue.
    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic        st;
        logic        done;
        logic [31:0] data;
        logic        jmp;
        logic [31:0] tgt;
    } ent_t;

    ent_t        rob_q[$];
    int          next_tag;
    logic        m_ena, m_st, m_rb;
    logic [4:0]  m_rd, m_q, m_sid;
    logic [31:0] m_data, m_tgt;

    task automatic model_reset();
        rob_q.delete();
        next_tag = 1;
        m_ena = 0; m_st = 0; m_rb = 0;
        m_rd = 0; m_q = 0; m_sid = 0; m_data = 0; m_tgt = 0;
    endtask

    function automatic int find(input logic [4:0] tag);
        foreach (rob_q[k]) if (rob_q[k].tag == tag) return k;
        return -1;
    endfunction

    task automatic exp_query(input logic [4:0] q, output logic r, output logic [31:0] v);
        int k;
        r = 0; v = 0;
        if (q == 0) begin
            r = 1;
        end else begin
            k = find(q);
            if (k >= 0) begin r = rob_q[k].done; v = rob_q[k].data; end
            if (lsb_valid && lsb_rob_id == q) begin r = 1; v = lsb_data; end
            if (alu_valid && alu_rob_id == q) begin r = 1; v = alu_data; end
        end
    endtask

    task automatic check_outputs();
        logic r; logic [31:0] v;
        chk("rob_id", 32'(rob_id_to_dsp), 32'(next_tag));
        chk("full", 32'(full_to_if), 32'(rob_q.size() >= ROB_SIZE - 1));
        exp_query(Q1_from_dsp, r, v);
        chk("q1_ready", 32'(Q1_ready_to_dsp), 32'(r));
        if (r) chk("v1", V1_to_dsp, v);
        exp_query(Q2_from_dsp, r, v);
        chk("q2_ready", 32'(Q2_ready_to_dsp), 32'(r));
        if (r) chk("v2", V2_to_dsp, v);
        chk("ena_to_reg", 32'(ena_to_reg), 32'(m_ena & rdy));
        chk("commit_store", 32'(commit_store_to_lsb), 32'(m_st & rdy));
        chk("rollback", 32'(rollback_flag), 32'(m_rb & rdy));
        if (m_ena) begin
            chk("rd_to_reg", 32'(rd_to_reg), 32'(m_rd));
            chk("Q_to_reg", 32'(Q_to_reg), 32'(m_q));
            chk("data_to_reg", data_to_reg, m_data);
        end
        if (m_st) chk("store_id", 32'(commit_rob_id_to_lsb), 32'(m_sid));
        if (m_rb) chk("target_pc", target_pc_to_if, m_tgt);
    endtask

    task automatic model_step();
        ent_t h;
        logic com;
        logic room;
        int   k;
        if (!rdy) return;
        room = rob_q.size() < ROB_SIZE;
        if (ena_from_dsp) chk("alloc_while_full", 32'(room), 32'd1);
        com = rob_q.size() > 0 && rob_q[0].done;
        if (com) h = rob_q[0];
        if (lsb_valid && !(alu_valid && alu_rob_id == lsb_rob_id)) begin
            k = find(lsb_rob_id);
            if (k >= 0) begin rob_q[k].done = 1; rob_q[k].data = lsb_data; end
        end
        if (alu_valid) begin
            k = find(alu_rob_id);
            if (k >= 0) begin
                rob_q[k].done = 1; rob_q[k].data = alu_data;
                rob_q[k].jmp = alu_jump; rob_q[k].tgt = alu_target;
            end
        end
        m_ena = com && !h.st;
        m_st  = com && h.st;
        m_rb  = com && h.jmp;
        if (m_ena) begin m_rd = h.rd; m_q = h.tag; m_data = h.data; end
        if (m_st) m_sid = h.tag;
        if (m_rb) m_tgt = h.tgt;
        if (com) begin
            $display("commit tag=%0d store=%0d rd=%0d data=%h jump=%0d", h.tag, h.st, h.rd, h.data, h.jmp);
            void'(rob_q.pop_front());
        end
        if (m_rb) begin
            rob_q.delete();
            next_tag = 1;
        end else if (ena_from_dsp && room) begin
            rob_q.push_back('{tag: 5'(next_tag), rd: rd_from_dsp, st: is_store_from_dsp,
                              done: 1'b0, data: 32'h0, jmp: 1'b0, tgt: 32'h0});
            next_tag = next_tag % ROB_SIZE + 1;
        end
    endtask

    // Called just after a rising edge with this cycle's inputs driven.
    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        ena_from_dsp = 0; is_store_from_dsp = 0;
        alu_valid = 0; alu_jump = 0; lsb_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        chk("rst_ena", 32'(ena_to_reg), 0);
        chk("rst_store", 32'(commit_store_to_lsb), 0);
        chk("rst_rollback", 32'(rollback_flag), 0);
        chk("rst_data", data_to_reg, 0);
        chk("rst_rob_id", 32'(rob_id_to_dsp), 1);
        chk("rst_full", 32'(full_to_if), 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic st);
        ena_from_dsp = 1; rd_from_dsp = rd; is_store_from_dsp = st;
        pc_from_dsp = $urandom;
        run_cycle();
    endtask

    function automatic logic [4:0] pick_src();
        if (rob_q.size() == 0 || $urandom_range(0, 3) == 0) return 5'd0;
        return rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
    endfunction

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1: three allocations, query an unresolved tag
        alloc(5'd1, 0);
        alloc(5'd2, 0);
        alloc(5'd3, 0);
        Q1_from_dsp = 5'd2;
        #1;
        chk("t1_rob_id", 32'(rob_id_to_dsp), 4);
        chk("t1_q1_ready", 32'(Q1_ready_to_dsp), 0);
        run_cycle();

        // 2: bypass from the ALU bus in the same cycle; head still pending
        alu_valid = 1; alu_rob_id = 5'd2; alu_data = 32'h55;
        #1;
        chk("t2_q1_ready", 32'(Q1_ready_to_dsp), 1);
        chk("t2_v1", V1_to_dsp, 32'h55);
        run_cycle();
        chk("t2_no_commit", 32'(ena_to_reg), 0);

        // 3: head resolves, commits in order
        alu_valid = 1; alu_rob_id = 5'd1; alu_data = 32'hAA;
        run_cycle();
        run_cycle();
        chk("t3_ena", 32'(ena_to_reg), 1);
        chk("t3_rd", 32'(rd_to_reg), 1);
        chk("t3_q", 32'(Q_to_reg), 1);
        chk("t3_data", data_to_reg, 32'hAA);
        run_cycle();
        chk("t3_second_q", 32'(Q_to_reg), 2);

        // 4: fill to ROB_SIZE-1, then commit and allocate together
        Q1_from_dsp = 0;
        for (int i = 0; i < ROB_SIZE - 2; i++) alloc(5'($urandom_range(1, 31)), 0);
        chk("t4_full", 32'(full_to_if), 1);
        chk("t4_rob_id", 32'(rob_id_to_dsp), 2);
        alu_valid = 1; alu_rob_id = 5'd3; alu_data = 32'h33;
        run_cycle();
        alloc(5'd9, 0);
        chk("t4_full_steady", 32'(full_to_if), 1);
        chk("t4_rob_id_next", 32'(rob_id_to_dsp), 3);
        chk("t4_commit_q", 32'(Q_to_reg), 3);

        // mid-operation reset with a commit pulse outstanding
        do_reset();

        // 5: store retires through the LSB path
        alloc(5'd0, 1);
        lsb_valid = 1; lsb_rob_id = 5'd1; lsb_data = 32'h77;
        run_cycle();
        run_cycle();
        chk("t5_store", 32'(commit_store_to_lsb), 1);
        chk("t5_store_id", 32'(commit_rob_id_to_lsb), 1);
        chk("t5_no_reg", 32'(ena_to_reg), 0);

        // 6: mispredicted jump at head flushes younger entries
        do_reset();
        alloc(5'd1, 0);
        alloc(5'd4, 0);
        alloc(5'd5, 0);
        alu_valid = 1; alu_rob_id = 5'd1; alu_data = 32'h1234;
        alu_jump = 1; alu_target = 32'h100;
        run_cycle();
        ena_from_dsp = 1; rd_from_dsp = 5'd6;
        run_cycle();
        chk("t6_rollback", 32'(rollback_flag), 1);
        chk("t6_target", target_pc_to_if, 32'h100);
        chk("t6_link", data_to_reg, 32'h1234);
        chk("t6_rob_id", 32'(rob_id_to_dsp), 1);
        chk("t6_full", 32'(full_to_if), 0);
        run_cycle();

        // random traffic, including freeze cycles
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int cand[$];
            int a;
            rdy = ($urandom_range(0, 9) != 0);
            if (rob_q.size() < ROB_SIZE && $urandom_range(0, 1) == 1) begin
                ena_from_dsp = 1;
                rd_from_dsp = 5'($urandom_range(0, 31));
                is_store_from_dsp = ($urandom_range(0, 3) == 0);
                pc_from_dsp = $urandom;
            end
            cand = {};
            foreach (rob_q[k]) if (!rob_q[k].done) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, cand.size() - 1);
                alu_valid = 1; alu_rob_id = rob_q[cand[a]].tag;
                alu_data = $urandom; alu_target = $urandom;
                alu_jump = !rob_q[cand[a]].st && ($urandom_range(0, 15) == 0);
                cand.delete(a);
            end
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                a = $urandom_range(0, cand.size() - 1);
                lsb_valid = 1; lsb_rob_id = rob_q[cand[a]].tag; lsb_data = $urandom;
            end
            Q1_from_dsp = pick_src();
            Q2_from_dsp = pick_src();
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
